// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared constants and tap-period helper for the decade tick
//               generator and its consumers.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

  localparam int SYS_CLK_HZ    = 50_000_000;
  localparam int DEF_PRE_DIV   = 50;
  localparam int DEF_STAGE_DIV = 10;
  localparam int DEF_N_STAGES  = 6;

  // Number of CLK edges between consecutive ticks of tap k:
  // PRE_DIV * STAGE_DIV^k.
  function automatic longint tap_period(input int k,
                                        input int pre_div   = DEF_PRE_DIV,
                                        input int stage_div = DEF_STAGE_DIV);
    longint p;
    p = longint'(pre_div);
    for (int i = 0; i < k; i++) begin
      p = p * longint'(stage_div);
    end
    return p;
  endfunction

endpackage
`default_nettype wire

// File: rtl/clk_tick_gen_div_stage.sv
`default_nettype none
// ============================================================================
// Module      : div_stage
// Description : One divide-by-DIV stage of the tick cascade. Counts on 'adv',
//               exposes combinational terminal/half strobes for the next stage
//               and registered tick / 50%-duty square outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module div_stage
  import clk_div_pkg::*;
#(
  parameter int DIV = DEF_STAGE_DIV
) (
  input  logic CLK,
  input  logic RST,
  input  logic SYNC,
  input  logic adv,
  output logic strobe,
  output logic half,
  output logic tick,
  output logic sq
);

  // A degenerate divisor is rejected by the top; keep the width sane anyway.
  localparam int W = (DIV < 2) ? 1 : $clog2(DIV);

  localparam logic [W-1:0] LAST      = W'(DIV - 1);
  localparam logic [W-1:0] HALF_LAST = W'(DIV / 2 - 1);
  localparam logic [W-1:0] ONE       = W'(1);

  logic [W-1:0] cnt;

  // Terminal and mid-period strobes ripple combinationally down the chain.
  assign strobe = adv & (cnt == LAST);
  assign half   = adv & (cnt == HALF_LAST);

  // Counter, registered tick and square wave; RST and SYNC both restart phase.
  always_ff @(posedge CLK) begin
    if (RST || SYNC) begin
      cnt  <= '0;
      tick <= 1'b0;
      sq   <= 1'b0;
    end else begin
      tick <= strobe;
      if (adv) begin
        cnt <= (cnt == LAST) ? '0 : cnt + ONE;
      end
      if (strobe || half) begin
        sq <= ~sq;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/clk_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : clk_tick_gen
// Description : Single-clock decade tick generator. A prescaler followed by
//               N_STAGES decade stages, all clock-enabled from CLK, each tap
//               giving a one-cycle tick and a 50%-duty square wave, with a
//               runtime tap selector.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_tick_gen
  import clk_div_pkg::*;
#(
  parameter int PRE_DIV   = DEF_PRE_DIV,
  parameter int STAGE_DIV = DEF_STAGE_DIV,
  parameter int N_STAGES  = DEF_N_STAGES,
  localparam int N_TAPS   = N_STAGES + 1,
  localparam int SEL_W    = (N_TAPS < 2) ? 1 : $clog2(N_TAPS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              SYNC,
  input  logic [SEL_W-1:0]  SEL,
  output logic [N_TAPS-1:0] tick,
  output logic [N_TAPS-1:0] sq,
  output logic              tick_sel,
  output logic              sq_sel
);

  // Selector space rounded up to a power of two; the padding reads as 0 so
  // out-of-range selects yield tick_sel = sq_sel = 0.
  localparam int PAD = 1 << SEL_W;

  if ((PRE_DIV % 2) != 0 || PRE_DIV < 2) begin : g_bad_pre_div
    $error("clk_tick_gen: PRE_DIV must be even and >= 2");
  end
  if ((STAGE_DIV % 2) != 0 || STAGE_DIV < 2) begin : g_bad_stage_div
    $error("clk_tick_gen: STAGE_DIV must be even and >= 2");
  end

  logic [N_TAPS-1:0] strobe;
  logic [N_TAPS-1:0] half;
  logic [PAD-1:0]    tick_pad;
  logic [PAD-1:0]    sq_pad;
  logic              unused_taps;

  // Half strobes are consumed inside each stage; the last terminal strobe
  // has no further stage to drive.
  assign unused_taps = &{1'b0, half, strobe[N_TAPS-1]};

  div_stage #(
    .DIV    (PRE_DIV)
  ) u_pre (
    .CLK    (CLK),
    .RST    (RST),
    .SYNC   (SYNC),
    .adv    (EN),
    .strobe (strobe[0]),
    .half   (half[0]),
    .tick   (tick[0]),
    .sq     (sq[0])
  );

  for (genvar k = 1; k < N_TAPS; k++) begin : g_stage
    div_stage #(
      .DIV    (STAGE_DIV)
    ) u_stage (
      .CLK    (CLK),
      .RST    (RST),
      .SYNC   (SYNC),
      .adv    (strobe[k-1]),
      .strobe (strobe[k]),
      .half   (half[k]),
      .tick   (tick[k]),
      .sq     (sq[k])
    );
  end

  assign tick_pad = PAD'(tick);
  assign sq_pad   = PAD'(sq);

  // Tap selector: plain mux of the registered outputs.
  always_comb begin
    tick_sel = tick_pad[SEL];
    sq_sel   = sq_pad[SEL];
  end

endmodule
`default_nettype wire

// File: tb/tb_clk_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_clk_tick_gen
// Description : Self-checking bench for clk_tick_gen in a small configuration
//               (PRE_DIV=4, STAGE_DIV=2, N_STAGES=2) against a phase-count
//               model, plus hand-computed directed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clk_tick_gen;
  import clk_div_pkg::*;

  localparam int PRE = 4;
  localparam int STG = 2;
  localparam int NS  = 2;

  logic       CLK  = 1'b0;
  logic       RST  = 1'b1;
  logic       EN   = 1'b0;
  logic       SYNC = 1'b0;
  logic [1:0] SEL  = 2'd0;
  logic [2:0] tick;
  logic [2:0] sq;
  logic       tick_sel;
  logic       sq_sel;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 CLK = ~CLK;

  clk_tick_gen #(
    .PRE_DIV   (PRE),
    .STAGE_DIV (STG),
    .N_STAGES  (NS)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .EN       (EN),
    .SYNC     (SYNC),
    .SEL      (SEL),
    .tick     (tick),
    .sq       (sq),
    .tick_sel (tick_sel),
    .sq_sel   (sq_sel)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: number of enabled edges since the last reset/restart. Tap k ticks
  // when that count reaches a multiple of its period on an enabled edge, and
  // its square wave is high in the second half of each period.
  longint ph      = 0;
  bit     en_last = 1'b0;
  bit     mvalid  = 1'b0;

  always @(posedge CLK) begin
    if (RST || SYNC) begin
      ph = 0; en_last = 1'b0; mvalid = 1'b1;
    end else if (EN) begin
      ph = ph + 1; en_last = 1'b1;
    end else begin
      en_last = 1'b0;
    end
  end

  function automatic logic [2:0] exp_tick();
    logic [2:0] e;
    for (int k = 0; k <= NS; k++) begin
      e[k] = en_last && ((ph % tap_period(k, PRE, STG)) == 0);
    end
    return e;
  endfunction

  function automatic logic [2:0] exp_sq();
    logic [2:0] e;
    longint p;
    for (int k = 0; k <= NS; k++) begin
      p = tap_period(k, PRE, STG);
      e[k] = (ph % p) >= (p / 2);
    end
    return e;
  endfunction

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    logic [2:0] et, es;
    if (mvalid) begin
      et = exp_tick();
      es = exp_sq();
      chk("model_tick", tick, et);
      chk("model_sq", sq, es);
      chk("model_tick_sel", tick_sel, (SEL <= 2'(NS)) ? et[SEL] : 1'b0);
      chk("model_sq_sel", sq_sel, (SEL <= 2'(NS)) ? es[SEL] : 1'b0);
    end
  end

  // Advance n edges and settle just after the last one.
  task automatic wait_e(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  logic [31:0] en_pat;

  initial begin
    en_pat = 32'hB5F3_0E9D;
    EN = 1'b1;
    wait_e(2);
    chk("reset_tick", tick, 0);
    chk("reset_sq", sq, 0);
    chk("reset_tick_sel", tick_sel, 0);
    chk("reset_sq_sel", sq_sel, 0);
    RST = 1'b0;

    // First periods after reset release.
    wait_e(2);  chk("sq0_rise_e2", sq[0], 1);   chk("tick_e2", tick, 0);
    wait_e(2);  chk("tick_e4", tick, 3'b001);   chk("sq0_fall_e4", sq[0], 0);
    wait_e(1);  chk("tick_e5", tick, 3'b000);
    wait_e(3);  chk("tick_e8", tick, 3'b011);   chk("sq_e8", sq, 3'b100);
    wait_e(4);  chk("tick_e12", tick, 3'b001);
    wait_e(4);  chk("tick_e16_wrap", tick, 3'b111); chk("sq_e16", sq, 3'b000);
    wait_e(1);  chk("tick_e17", tick, 3'b000);

    // Reset mid-run discards the phase; first-period timing repeats.
    RST = 1'b1; wait_e(1); RST = 1'b0;
    wait_e(7);
    RST = 1'b1; wait_e(1);
    chk("rst_mid_tick", tick, 0); chk("rst_mid_sq", sq, 0);
    RST = 1'b0;
    wait_e(2);  chk("rst_sq0_rise", sq[0], 1);
    wait_e(2);  chk("rst_tick_e4", tick, 3'b001);

    // Pause for 5 edges after edge 6 of a fresh run.
    RST = 1'b1; wait_e(1); RST = 1'b0;
    wait_e(6);
    EN = 1'b0;
    wait_e(3);  chk("pause_tick", tick, 0); chk("pause_sq", sq, 3'b011);
    wait_e(2);
    EN = 1'b1;
    wait_e(1);  chk("resume_e12", tick, 0);
    wait_e(1);  chk("resume_e13", tick, 3'b011);

    // Phase restart.
    SYNC = 1'b1; wait_e(1);
    chk("sync_tick", tick, 0); chk("sync_sq", sq, 0);
    SYNC = 1'b0;
    wait_e(3);  chk("sync_e3", tick, 0);
    wait_e(1);  chk("sync_e4", tick, 3'b001);

    // Restart is honoured even while paused.
    wait_e(6);
    EN = 1'b0; SYNC = 1'b1; wait_e(1);
    chk("sync_paused_sq", sq, 0);
    SYNC = 1'b0; EN = 1'b1;
    wait_e(4);  chk("sync_paused_e4", tick, 3'b001);

    // Selector sweep including the out-of-range code.
    for (int s = 0; s < 4; s++) begin
      SEL = 2'(s);
      wait_e(16);
      if (s == 3) begin
        chk("sel3_tick_sel", tick_sel, 0);
        chk("sel3_sq_sel", sq_sel, 0);
      end
    end

    // Irregular enable pattern against the model.
    for (int i = 0; i < 64; i++) begin
      EN  = en_pat[i % 32];
      SEL = 2'(i % 3);
      wait_e(1);
    end
    EN = 1'b1;
    wait_e(40);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/clk_tick_gen.md
Name: clk_tick_gen

Overview:
- Parametrised, single-clock decade tick generator; successor to the ripple-clocked 50 MHz -> 1 Hz divider chain.
- All stages run on CLK and advance through clock enables. No derived clocks are generated.
- Each tap provides a one-cycle tick strobe and a 50%-duty square wave. A runtime selector muxes one tap to a dedicated output.
- Also adds pause (EN) and phase restart (SYNC) behaviour.
- Consumers: display refresh, debounce, timekeeping logic.

Parameters:
- PRE_DIV, 50, prescaler divisor for tap 0 (50 MHz -> 1 MHz); must be even and >= 2.
- STAGE_DIV, 10, divisor of every subsequent stage; must be even and >= 2.
- N_STAGES, 6, number of stages after the prescaler; taps are 0..N_STAGES.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  count enable; low pauses all counters.
- SYNC  in  1  synchronous phase restart.
- SEL  in  $clog2(N_STAGES+1)  tap select for tick_sel/sq_sel.
- tick  out  N_STAGES+1  per-tap one-CLK-cycle strobes; bit k = tap k.
- sq  out  N_STAGES+1  per-tap 50%-duty square waves.
- tick_sel  out  1  tick[SEL].
- sq_sel  out  1  sq[SEL].

Behaviour:
- Reset:
  - RST is sampled on the CLK rising edge.
  - All counters, tick and sq clear to 0; tick_sel and sq_sel read 0.
- Priority: RST > SYNC > EN.
- Stage 0 counter:
  - Width $clog2(PRE_DIV). Counts 0..PRE_DIV-1 and wraps to 0.
  - Advances on every CLK edge where EN=1.
- Stage k counter (k >= 1):
  - Width $clog2(STAGE_DIV). Counts 0..STAGE_DIV-1 and wraps.
  - Advances only on edges where strobe[k-1]=1.
- Internal strobes (combinational):
  - strobe[0] = EN & (cnt0 == PRE_DIV-1).
  - strobe[k] = strobe[k-1] & (cntk == STAGE_DIV-1).
  - half[k] uses the same chain with terminal value DIV/2-1.
  - The whole cascade resolves within one cycle, so tap k does not accumulate extra latency.
- Outputs are registered, with uniform 1-cycle latency:
  - tick[k] <= strobe[k].
  - sq[k] toggles on edges where strobe[k] | half[k].
- Timing with EN held high from reset release:
  - tick[k] first rises after edge PRE_DIV*STAGE_DIV^k, then every PRE_DIV*STAGE_DIV^k edges.
  - tick[k] is exactly 1 cycle wide.
  - sq[k] rises after edge (PRE_DIV*STAGE_DIV^k)/2 and falls after edge PRE_DIV*STAGE_DIV^k.
- Simultaneous wrap: all taps may tick on the same edge (e.g. tap 0..N all wrap together). Each asserted tick bit is still one cycle wide.
- EN=0:
  - Counters and sq hold their values; tick is forced to 0 on the next edge.
  - On resume, counting continues from the held phase with no lost or extra ticks.
- SYNC=1: same effect as reset (counters, tick, sq := 0), applied regardless of EN.
  - Counting restarts on the first edge after SYNC deasserts.
  - A SYNC mid-period discards the partial period.
- SEL:
  - Purely combinational mux of the registered tick/sq.
  - SEL > N_STAGES drives tick_sel=0 and sq_sel=0.
  - Changing SEL mid-period may produce a truncated sq_sel phase; that is allowed.
- Width rule: no counter ever exceeds DIV-1. Terminal compares use full counter width, with no truncation.
- Elaboration: if a divisor is odd or < 2, the block raises an $error at elaboration.

Decomposition:
- Shared package clk_div_pkg holds:
  - default constants: SYS_CLK_HZ=50_000_000, DEF_PRE_DIV=50, DEF_STAGE_DIV=10, DEF_N_STAGES=6;
  - function tap_period(k) returning PRE_DIV*STAGE_DIV^k, used by the bench.
- One sub-module, div_stage:
  - parameter DIV;
  - inputs: CLK, RST, SYNC, adv;
  - outputs: strobe, half, registered tick, sq.
  - Instantiated once with DIV=PRE_DIV (adv=EN) and N_STAGES times with DIV=STAGE_DIV (adv=strobe[k-1]) in a generate loop.

Test Plan:
- Small config (PRE_DIV=4, STAGE_DIV=2, N_STAGES=2), EN=1 after reset:
  - tick[0] high after edges 4, 8, 12…;
  - tick[1] after edges 8, 16…;
  - tick[2] after edges 16, 32…;
  - sq[0] rises after edge 2 and falls after edge 4.
- Same config, simultaneous wrap: after edge 16, tick = 3'b111 for exactly one cycle, then 3'b000.
- EN dropped for 5 cycles starting after edge 6:
  - tick stays 0 and sq holds during the pause;
  - after resume, tick[0] next fires after edge 13 (4+4+5), with no extra or missing pulses.
- SYNC pulsed after edge 10: all outputs read 0 on the next cycle, and tick[0] next fires 4 edges after SYNC deasserts.
- RST asserted mid-run (after edge 7) for 1 cycle: tick=0 and sq=0 on the following cycle, and the first-period timing then repeats exactly.
- SEL sweep 0..3 with N_STAGES=2:
  - tick_sel mirrors tick[SEL];
  - SEL=3 gives tick_sel=0 and sq_sel=0;
  - default config: tick[6] period = 50,000,000 edges (1 Hz).
